// File: rtl/spi_sclk_ctrl.sv
// Programmable SPI serial-clock sequencer: divides i_clk into SCLK, frames CS,
// and issues single-cycle shift/sample strobes for all four CPOL/CPHA modes.
module spi_sclk_ctrl #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [DIV_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_cpol,
  input  logic             i_cpha,
  output logic             o_sclk,
  output logic             o_cs_n,
  output logic             o_busy,
  output logic             o_shift,
  output logic             o_sample,
  output logic             o_done
);

  typedef enum logic [1:0] {IDLE, LEAD, RUN, TRAIL} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   edge_q, edge_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             done_q, done_d;

  logic             cnt_term;
  logic [CNT_W:0]   edge_nx;
  logic             edge_last;
  logic             edge_lead;

  assign cnt_term  = (cnt_q == div_q);
  assign edge_nx   = edge_q + (CNT_W+1)'(1);
  assign edge_last = (edge_nx == {nbits_q, 1'b0});
  assign edge_lead = ~edge_q[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = i_cpol;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (i_start && (i_nbits != '0)) begin
          div_d   = i_div;
          nbits_d = i_nbits;
          cpol_d  = i_cpol;
          cpha_d  = i_cpha;
          cnt_d   = '0;
          edge_d  = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          shift_d = ~i_cpha;
          state_d = LEAD;
        end
      end
      // LEAD's terminal count produces edge 1, so LEAD and RUN share the edge logic.
      LEAD, RUN: begin
        if (cnt_term) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_nx;
          if (edge_lead) begin
            sample_d = ~cpha_q;
            shift_d  = cpha_q;
          end else begin
            sample_d = cpha_q;
            shift_d  = ~cpha_q & ~edge_last;
          end
          state_d = edge_last ? TRAIL : RUN;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (cnt_term) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      edge_d   = '0;
      sclk_d   = cpol_q;
      cs_n_d   = 1'b1;
      busy_d   = 1'b0;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      div_q    <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign o_sclk   = sclk_q;
  assign o_cs_n   = cs_n_q;
  assign o_busy   = busy_q;
  assign o_shift  = shift_q;
  assign o_sample = sample_q;
  assign o_done   = done_q;

endmodule
